// File: rtl/sdram_port_arb_if.sv
// Bundle of requester-side and controller-side signals around the SDRAM port arbiter.
// slave: the arbiter's view; master: the requesters plus controller around it.
interface sdram_port_arb_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
);
  logic [2:0]          req_rd;
  logic [2:0]          req_wr;
  logic [3*ADDR_W-1:0] req_addr;
  logic [3*DATA_W-1:0] req_wdata;
  logic [2:0]          req_ack;
  logic [2:0]          req_err;
  logic [DATA_W-1:0]   req_rdata;
  logic [ADDR_W-1:0]   s_address;
  logic [DATA_W-1:0]   s_data_in;
  logic [DATA_W-1:0]   s_data_out;
  logic                s_read_req;
  logic                s_write_req;
  logic                s_read_ack;
  logic                s_write_ack;
  logic                busy;
  logic [1:0]          grant;

  modport slave (
    input  req_rd, req_wr, req_addr, req_wdata, s_data_out, s_read_ack, s_write_ack,
    output req_ack, req_err, req_rdata, s_address, s_data_in, s_read_req, s_write_req,
           busy, grant
  );

  modport master (
    output req_rd, req_wr, req_addr, req_wdata, s_data_out, s_read_ack, s_write_ack,
    input  req_ack, req_err, req_rdata, s_address, s_data_in, s_read_req, s_write_req,
           busy, grant
  );
endinterface

// File: rtl/sdram_port_arb.sv
// Three-port transaction arbiter in front of a single-word SDRAM controller port.
// Define SDRAM_ARB_PRIO_EN to give port 0 fixed priority (ports 1/2 round-robin).
//
// state    | meaning
// S_IDLE   | waiting for a request with both controller acks low
// S_ISSUE  | raise s_read_req or s_write_req, clear timeout counter
// S_WAIT   | hold request until matching ack or timeout
// S_RESP   | ack/err to granted port until it and the controller release
module sdram_port_arb #(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input logic              sys_clk,
  input logic              sys_rst_n,
  sdram_port_arb_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [1:0] rr;
  logic [7:0] cnt;
  logic       op_wr;
  logic [2:0] pend;
  logic [1:0] pick;
  logic       pick_vld;
  logic       acks_low;
  logic       ack_match;

  assign pend      = bus.req_rd | bus.req_wr;
  assign acks_low  = !bus.s_read_ack && !bus.s_write_ack;
  assign ack_match = op_wr ? bus.s_write_ack : bus.s_read_ack;

`ifdef SDRAM_ARB_PRIO_EN
  always_comb begin
    pick     = 2'd0;
    pick_vld = 1'b1;
    if (pend[0])        pick = 2'd0;
    else if (rr == 2'd1) begin
      if (pend[2])      pick = 2'd2;
      else if (pend[1]) pick = 2'd1;
      else              pick_vld = 1'b0;
    end else begin
      if (pend[1])      pick = 2'd1;
      else if (pend[2]) pick = 2'd2;
      else              pick_vld = 1'b0;
    end
  end
`else
  logic [1:0] c0;
  logic [1:0] c1;

  assign c0 = (rr == 2'd2) ? 2'd0 : rr + 2'd1;
  assign c1 = (c0 == 2'd2) ? 2'd0 : c0 + 2'd1;

  always_comb begin
    pick     = 2'd0;
    pick_vld = 1'b1;
    if (pend[c0])      pick = c0;
    else if (pend[c1]) pick = c1;
    else if (pend[rr]) pick = rr;
    else               pick_vld = 1'b0;
  end
`endif

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state           <= S_IDLE;
      rr              <= 2'd2;
      cnt             <= 8'd0;
      op_wr           <= 1'b0;
      bus.grant       <= 2'd0;
      bus.busy        <= 1'b0;
      bus.s_address   <= '0;
      bus.s_data_in   <= '0;
      bus.s_read_req  <= 1'b0;
      bus.s_write_req <= 1'b0;
      bus.req_ack     <= 3'b000;
      bus.req_err     <= 3'b000;
      bus.req_rdata   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // A late ack from an aborted transfer must clear before anything new is issued.
          if (pick_vld && acks_low) begin
            bus.grant     <= pick;
`ifdef SDRAM_ARB_PRIO_EN
            if (pick != 2'd0) rr <= pick;
`else
            rr <= pick;
`endif
            bus.s_address <= bus.req_addr[int'(pick)*ADDR_W +: ADDR_W];
            bus.s_data_in <= bus.req_wdata[int'(pick)*DATA_W +: DATA_W];
            op_wr         <= bus.req_wr[pick];
            bus.busy      <= 1'b1;
            if (bus.req_rd[pick] && bus.req_wr[pick]) begin
              bus.req_ack <= 3'b001 << pick;
              bus.req_err <= 3'b001 << pick;
              state       <= S_RESP;
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          bus.s_read_req  <= !op_wr;
          bus.s_write_req <= op_wr;
          cnt             <= 8'd0;
          state           <= S_WAIT;
        end
        S_WAIT: begin
          if (ack_match) begin
            if (!op_wr) bus.req_rdata <= bus.s_data_out;
            bus.s_read_req  <= 1'b0;
            bus.s_write_req <= 1'b0;
            bus.req_ack     <= 3'b001 << bus.grant;
            bus.req_err     <= 3'b000;
            state           <= S_RESP;
          end else if (cnt == TO_LAST) begin
            bus.s_read_req  <= 1'b0;
            bus.s_write_req <= 1'b0;
            bus.req_ack     <= 3'b001 << bus.grant;
            bus.req_err     <= 3'b001 << bus.grant;
            bus.req_rdata   <= '0;
            state           <= S_RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_RESP: begin
          if (!bus.req_rd[bus.grant] && !bus.req_wr[bus.grant] && acks_low) begin
            bus.req_ack <= 3'b000;
            bus.req_err <= 3'b000;
            bus.busy    <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arb.sv
// Directed bench for sdram_port_arb: handshake, read data, fairness, timeout,
// protocol error and reset-during-transfer scenarios.
module tb_sdram_port_arb;
  localparam int AW = 24;
  localparam int DW = 16;
  localparam int TO = 16;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  int   checks    = 0;
  int   errors    = 0;

  sdram_port_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  sdram_port_arb #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic idle_inputs();
    bus.req_rd      = 3'b000;
    bus.req_wr      = 3'b000;
    bus.req_addr    = '0;
    bus.req_wdata   = '0;
    bus.s_data_out  = '0;
    bus.s_read_ack  = 1'b0;
    bus.s_write_ack = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic wait_sreq(input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge sys_clk);
      if (bus.s_read_req || bus.s_write_req) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: s_*_req stayed low for 50 cycles, required high", tag);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    apply_reset();
    checks++;
    if ({bus.req_ack, bus.req_err, bus.req_rdata, bus.s_address, bus.s_data_in,
         bus.s_read_req, bus.s_write_req, bus.busy, bus.grant} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b err=%b rdata=%h addr=%h busy=%b grant=%0d, required all 0",
               bus.req_ack, bus.req_err, bus.req_rdata, bus.s_address, bus.busy, bus.grant);
    end
  endtask

  task automatic test_write();
    @(negedge sys_clk);
    bus.req_wr                 = 3'b010;
    bus.req_addr[1*AW +: AW]   = 24'h000012;
    bus.req_wdata[1*DW +: DW]  = 16'h4433;
    @(negedge sys_clk);
    checks++;
    if (bus.grant !== 2'd1 || bus.busy !== 1'b1 || bus.s_write_req !== 1'b0) begin
      errors++;
      $display("FAIL w_grant: grant=%0d busy=%b s_write_req=%b, required 1 1 0",
               bus.grant, bus.busy, bus.s_write_req);
    end
    @(negedge sys_clk);
    checks++;
    if (bus.s_write_req !== 1'b1 || bus.s_read_req !== 1'b0 ||
        bus.s_address !== 24'h000012 || bus.s_data_in !== 16'h4433) begin
      errors++;
      $display("FAIL w_issue: wr=%b rd=%b addr=%h data=%h, required 1 0 000012 4433",
               bus.s_write_req, bus.s_read_req, bus.s_address, bus.s_data_in);
    end
    repeat (4) @(negedge sys_clk);
    checks++;
    if (bus.s_write_req !== 1'b1 || bus.req_ack !== 3'b000) begin
      errors++;
      $display("FAIL w_hold: wr=%b ack=%b, required 1 000", bus.s_write_req, bus.req_ack);
    end
    bus.s_write_ack = 1'b1;
    @(negedge sys_clk);
    checks++;
    if (bus.req_ack !== 3'b010 || bus.req_err !== 3'b000 || bus.s_write_req !== 1'b0) begin
      errors++;
      $display("FAIL w_ack: ack=%b err=%b wr=%b, required 010 000 0",
               bus.req_ack, bus.req_err, bus.s_write_req);
    end
    bus.req_wr      = 3'b000;
    bus.s_write_ack = 1'b0;
    @(negedge sys_clk);
    checks++;
    if (bus.req_ack !== 3'b000 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL w_release: ack=%b busy=%b, required 000 0", bus.req_ack, bus.busy);
    end
  endtask

  task automatic test_read();
    bit ok;
    @(negedge sys_clk);
    bus.req_rd               = 3'b001;
    bus.req_addr[0 +: AW]    = 24'h0000A5;
    wait_sreq("r_issue", ok);
    if (!ok) return;
    checks++;
    if (bus.s_read_req !== 1'b1 || bus.s_address !== 24'h0000A5 || bus.grant !== 2'd0) begin
      errors++;
      $display("FAIL r_issue: rd=%b addr=%h grant=%0d, required 1 0000a5 0",
               bus.s_read_req, bus.s_address, bus.grant);
    end
    bus.s_data_out = 16'h3F70;
    bus.s_read_ack = 1'b1;
    @(negedge sys_clk);
    checks++;
    if (bus.req_ack !== 3'b001 || bus.req_rdata !== 16'h3F70 || bus.req_err !== 3'b000) begin
      errors++;
      $display("FAIL r_data: ack=%b rdata=%h err=%b, required 001 3f70 000",
               bus.req_ack, bus.req_rdata, bus.req_err);
    end
    bus.s_read_ack = 1'b0;
    bus.s_data_out = 16'hDEAD;
    @(negedge sys_clk);
    checks++;
    if (bus.req_ack !== 3'b001 || bus.req_rdata !== 16'h3F70) begin
      errors++;
      $display("FAIL r_hold: ack=%b rdata=%h, required 001 3f70", bus.req_ack, bus.req_rdata);
    end
    bus.req_rd = 3'b000;
    @(negedge sys_clk);
    checks++;
    if (bus.req_ack !== 3'b000) begin
      errors++;
      $display("FAIL r_release: ack=%b, required 000", bus.req_ack);
    end
  endtask

  task automatic test_fairness();
    bit         ok;
    logic [1:0] g;
    logic [1:0] exp;
    idle_inputs();
    apply_reset();
    for (int p = 0; p < 3; p++) bus.req_addr[p*AW +: AW] = 24'h000100 + 24'(p);
    bus.req_rd = 3'b111;
    for (int k = 0; k < 6; k++) begin
      wait_sreq("fair_issue", ok);
      if (!ok) break;
`ifdef SDRAM_ARB_PRIO_EN
      exp = 2'd0;
`else
      exp = 2'(k % 3);
`endif
      checks++;
      if (bus.grant !== exp || bus.s_address !== 24'h000100 + 24'(exp)) begin
        errors++;
        $display("FAIL fair_grant[%0d]: grant=%0d addr=%h, required %0d %h",
                 k, bus.grant, bus.s_address, exp, 24'h000100 + 24'(exp));
      end
      g              = bus.grant;
      bus.s_data_out = 16'h5A00 + 16'(k);
      bus.s_read_ack = 1'b1;
      @(negedge sys_clk);
      checks++;
      if (bus.req_ack !== (3'b001 << exp) || bus.req_rdata !== 16'h5A00 + 16'(k)) begin
        errors++;
        $display("FAIL fair_ack[%0d]: ack=%b rdata=%h, required %b %h",
                 k, bus.req_ack, bus.req_rdata, 3'b001 << exp, 16'h5A00 + 16'(k));
      end
      bus.s_read_ack = 1'b0;
      if (k == 5) bus.req_rd = 3'b000;
      else        bus.req_rd[g] = 1'b0;
      @(negedge sys_clk);
      if (k != 5) bus.req_rd[g] = 1'b1;
    end
    bus.req_rd = 3'b000;
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    @(negedge sys_clk);
    bus.req_rd               = 3'b010;
    bus.req_addr[1*AW +: AW] = 24'h000077;
    wait_sreq("to_issue", ok);
    if (!ok) return;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge sys_clk);
      n++;
      if (!bus.s_read_req) break;
    end
    checks++;
    if (n !== TO) begin
      errors++;
      $display("FAIL to_cycles: s_read_req high for %0d cycles, required %0d", n, TO);
    end
    checks++;
    if (bus.req_ack !== 3'b010 || bus.req_err !== 3'b010 || bus.req_rdata !== 16'h0000) begin
      errors++;
      $display("FAIL to_resp: ack=%b err=%b rdata=%h, required 010 010 0000",
               bus.req_ack, bus.req_err, bus.req_rdata);
    end
    bus.req_rd = 3'b000;
    @(negedge sys_clk);
    @(negedge sys_clk);
    bus.req_rd = 3'b010;
    wait_sreq("to_next", ok);
    if (!ok) return;
    bus.s_data_out = 16'h1234;
    bus.s_read_ack = 1'b1;
    @(negedge sys_clk);
    checks++;
    if (bus.req_ack !== 3'b010 || bus.req_err !== 3'b000 || bus.req_rdata !== 16'h1234) begin
      errors++;
      $display("FAIL to_next: ack=%b err=%b rdata=%h, required 010 000 1234",
               bus.req_ack, bus.req_err, bus.req_rdata);
    end
    bus.s_read_ack = 1'b0;
    bus.req_rd     = 3'b000;
    @(negedge sys_clk);
  endtask

  task automatic test_protocol_err();
    bit saw;
    @(negedge sys_clk);
    bus.req_rd = 3'b100;
    bus.req_wr = 3'b100;
    @(negedge sys_clk);
    saw = bus.s_read_req | bus.s_write_req;
    checks++;
    if (bus.req_ack !== 3'b100 || bus.req_err !== 3'b100 || bus.grant !== 2'd2) begin
      errors++;
      $display("FAIL perr_resp: ack=%b err=%b grant=%0d, required 100 100 2",
               bus.req_ack, bus.req_err, bus.grant);
    end
    repeat (3) begin
      @(negedge sys_clk);
      saw = saw | bus.s_read_req | bus.s_write_req;
    end
    checks++;
    if (saw !== 1'b0 || bus.req_ack !== 3'b100) begin
      errors++;
      $display("FAIL perr_nodown: s_req_seen=%b ack=%b, required 0 100", saw, bus.req_ack);
    end
    bus.req_rd = 3'b000;
    bus.req_wr = 3'b000;
    @(negedge sys_clk);
    checks++;
    if (bus.req_ack !== 3'b000 || bus.req_err !== 3'b000) begin
      errors++;
      $display("FAIL perr_release: ack=%b err=%b, required 000 000", bus.req_ack, bus.req_err);
    end
  endtask

  task automatic test_reset_in_wait();
    bit ok;
    @(negedge sys_clk);
    bus.req_addr[0 +: AW]    = 24'h000055;
    bus.req_addr[1*AW +: AW] = 24'h000066;
    bus.req_rd               = 3'b010;
    wait_sreq("rst_issue", ok);
    if (!ok) return;
    sys_rst_n      = 1'b0;
    bus.s_read_ack = 1'b1;
    @(negedge sys_clk);
    checks++;
    if ({bus.req_ack, bus.req_err, bus.req_rdata, bus.s_address, bus.s_data_in,
         bus.s_read_req, bus.s_write_req, bus.busy, bus.grant} !== '0) begin
      errors++;
      $display("FAIL rst_wait: ack=%b rd=%b addr=%h busy=%b grant=%0d, required all 0",
               bus.req_ack, bus.s_read_req, bus.s_address, bus.busy, bus.grant);
    end
    sys_rst_n  = 1'b1;
    bus.req_rd = 3'b011;
    repeat (3) @(negedge sys_clk);
    checks++;
    if (bus.s_read_req !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_holdoff: rd=%b busy=%b, required 0 0", bus.s_read_req, bus.busy);
    end
    bus.s_read_ack = 1'b0;
    wait_sreq("rst_next", ok);
    if (!ok) return;
    checks++;
    if (bus.grant !== 2'd0 || bus.s_address !== 24'h000055) begin
      errors++;
      $display("FAIL rst_first: grant=%0d addr=%h, required 0 000055", bus.grant, bus.s_address);
    end
    bus.s_read_ack = 1'b1;
    @(negedge sys_clk);
    checks++;
    if (bus.req_ack !== 3'b001) begin
      errors++;
      $display("FAIL rst_ack: ack=%b, required 001", bus.req_ack);
    end
    bus.s_read_ack = 1'b0;
    bus.req_rd     = 3'b000;
    repeat (2) @(negedge sys_clk);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_fairness();
    test_timeout();
    test_protocol_err();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
